aes_round_sequencer: RTL

- Sequences one AES-128 encryption through a shared, registered round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) that lives outside this block.
- Accepts a plaintext block on a valid/ready handshake and performs the initial AddRoundKey itself.
- Issues NR rounds to the datapath, selects the round-key index, and flags the final round so MixColumns is bypassed.
- Sits between the block-level input FIFO and the key-schedule/round-datapath pair; returns ciphertext on a valid/ready handshake.

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_round_ctr.sv | 36 +++
 rtl/aes_round_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, round count and sequencer state encoding.
package aes_pkg;
    localparam int AES_BLOCK_W  = 128;
    localparam int AES_RK_IDX_W = 4;
    localparam int AES128_NR    = 10;
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} seq_state_e;
endpackage

// File: rtl/aes_round_ctr.sv
// aes_round_ctr: round index and datapath-latency counters for the AES round sequencer.
module aes_round_ctr
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int DP_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    run,
    input  logic                    clr,
    output logic [AES_RK_IDX_W-1:0] round,
    output logic                    round_done,
    output logic                    last_round
);
    logic [2:0] lat_cnt;
    assign round_done = run && (lat_cnt == 3'(DP_LAT));
    assign last_round = round == AES_RK_IDX_W'(NR);
    // the round index returns to 0 as the last round completes, so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round   <= '0;
            lat_cnt <= '0;
        end else if (clr) begin
            round   <= '0;
            lat_cnt <= '0;
        end else if (start) begin
            round   <= AES_RK_IDX_W'(1);
            lat_cnt <= '0;
        end else if (run) begin
            lat_cnt <= round_done ? '0 : lat_cnt + 3'd1;
            if (round_done) round <= last_round ? '0 : round + AES_RK_IDX_W'(1);
        end
    end
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: sequences one AES-128 block through an external registered round datapath.
// Defining AES_SEQ_ABORT_EN adds an abort input that returns a busy sequencer to IDLE.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int DP_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef AES_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AES_BLOCK_W-1:0]  in_block,
    output logic [AES_RK_IDX_W-1:0] rk_idx,
    input  logic [AES_BLOCK_W-1:0]  rk_data,
    output logic [AES_BLOCK_W-1:0]  rnd_in,
    output logic                    rnd_last,
    input  logic [AES_BLOCK_W-1:0]  rnd_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AES_BLOCK_W-1:0]  out_block,
    output logic                    busy
);
    seq_state_e              fsm;
    logic [AES_BLOCK_W-1:0]  st;
    logic [AES_RK_IDX_W-1:0] round;
    logic                    round_done, last_round, accept, abort_req;
`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort && (fsm != IDLE);
`else
    assign abort_req = 1'b0;
`endif
    assign accept    = in_valid && in_ready;
    assign rk_idx    = (fsm == ROUND) ? round : '0;
    assign rnd_last  = (fsm == ROUND) && last_round;
    assign rnd_in    = st;
    assign out_block = st;

    aes_round_ctr #(.NR(NR), .DP_LAT(DP_LAT)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept),
        .run       (fsm == ROUND),
        .clr       (abort_req),
        .round     (round),
        .round_done(round_done),
        .last_round(last_round)
    );

    // abort leaves the state register untouched so out_block keeps its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            st        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else if (abort_req) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (fsm)
                IDLE: if (accept) begin
                    st       <= in_block ^ rk_data;
                    fsm      <= ROUND;
                    busy     <= 1'b1;
                    in_ready <= 1'b0;
                end
                ROUND: if (round_done) begin
                    st <= rnd_out;
                    if (last_round) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
